// File: rtl/perm_restore.sv
// Inverse of the four-element sorting network. It accepts a sorted word together with
// the rank of each original element, then streams the elements back out in original order.
module perm_restore #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*W-1:0] sorted,
    input  logic [7:0]     perm,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_idx,
    output logic           out_last,
    output logic           err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     j_q, j_d;
    logic [4*W-1:0] sorted_q, sorted_d;
    logic [7:0]     perm_q, perm_d;
    logic           err_q, err_d;

    // The perm word is usable only if its four rank fields are pairwise distinct.
    function automatic logic perm_is_valid(input logic [7:0] p);
        logic [1:0] f0, f1, f2, f3;
        f0 = p[1:0];
        f1 = p[3:2];
        f2 = p[5:4];
        f3 = p[7:6];
        return (f0 != f1) && (f0 != f2) && (f0 != f3) &&
               (f1 != f2) && (f1 != f3) && (f2 != f3);
    endfunction

    function automatic logic [1:0] perm_field(input logic [7:0] p, input logic [1:0] j);
        case (j)
            2'd0:    return p[1:0];
            2'd1:    return p[3:2];
            2'd2:    return p[5:4];
            2'd3:    return p[7:6];
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] slot_sel(input logic [4*W-1:0] s, input logic [1:0] k);
        case (k)
            2'd0:    return s[W-1:0];
            2'd1:    return s[2*W-1:W];
            2'd2:    return s[3*W-1:2*W];
            2'd3:    return s[4*W-1:3*W];
            default: return '0;
        endcase
    endfunction

    // Next-state logic: accept or reject a word in IDLE, then step through the four beats.
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        sorted_d = sorted_q;
        perm_d   = perm_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (perm_is_valid(perm)) begin
                        sorted_d = sorted;
                        perm_d   = perm;
                        j_d      = 2'd0;
                        state_d  = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (j_q == 2'd3) begin
                        j_d     = 2'd0;
                        state_d = IDLE;
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end else begin
                    j_d = j_q;
                end
            end
            default: begin
                state_d = IDLE;
                j_d     = 2'd0;
            end
        endcase
    end

    // State and captured-word registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            j_q      <= 2'd0;
            sorted_q <= '0;
            perm_q   <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            sorted_q <= sorted_d;
            perm_q   <= perm_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode registered state only, so nothing on the inputs reaches them combinationally.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SEND);
        err       = err_q;
        if (state_q == SEND) begin
            out_data = slot_sel(sorted_q, perm_field(perm_q, j_q));
            out_idx  = j_q;
            out_last = (j_q == 2'd3);
        end else begin
            out_data = '0;
            out_idx  = 2'd0;
            out_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_perm_restore.sv
// Randomized and directed bench for perm_restore, checked against a queue-based beat model.
module tb_perm_restore;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sorted;
    logic [7:0]  perm;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        err;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    rnd_mode = 1'b0;
    bit    m_err    = 1'b0;
    beat_t exp_q[$];
    beat_t log_q[$];
    int    acc_q[$];
    int    lastx_q[$];

    perm_restore #(.W(4)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sorted   (sorted),
        .perm     (perm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a word is a list of four beats; element j is the sorted slot named by rank j.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_q.delete();
            m_err = 1'b0;
        end else begin
            bit err_n;
            err_n = 1'b0;
            if (exp_q.size() != 0) begin
                if (out_ready) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    log_q.push_back('{idx: out_idx, data: out_data});
                    if (b.idx == 2'd3) lastx_q.push_back(cyc);
                end
            end else if (in_valid) begin
                int cnt[4];
                bit ok;
                ok = 1'b1;
                for (int k = 0; k < 4; k++) cnt[k] = 0;
                for (int k = 0; k < 4; k++) cnt[(perm >> (2 * k)) & 3]++;
                for (int k = 0; k < 4; k++) if (cnt[k] != 1) ok = 1'b0;
                if (ok) begin
                    for (int k = 0; k < 4; k++) begin
                        int rank;
                        rank = (perm >> (2 * k)) & 3;
                        exp_q.push_back('{idx: 2'(k), data: 4'((sorted >> (4 * rank)) & 16'hF)});
                    end
                    acc_q.push_back(cyc);
                end else begin
                    err_n = 1'b1;
                end
            end
            m_err = err_n;
            cyc++;
        end
    end

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", in_ready, exp_q.size() == 0);
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("err", err, m_err);
        if (exp_q.size() != 0) begin
            chk("out_idx", out_idx, exp_q[0].idx);
            chk("out_data", out_data, exp_q[0].data);
            chk("out_last", out_last, exp_q[0].idx == 2'd3);
        end
    end

    always @(negedge clk) begin
        if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Offer a word starting at a negedge; returns at the negedge after the accepting edge.
    task automatic offer(input logic [15:0] s, input logic [7:0] p, input bit keep);
        int n;
        sorted   = s;
        perm     = p;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_log(input string nm, input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
        logic [3:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_len"}, log_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < log_q.size()) begin
                chk({nm, "_idx"}, log_q[k].idx, k);
                chk({nm, "_data"}, log_q[k].data, e[k]);
            end
        end
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_in_ready"}, in_ready, 32'd1);
        chk({nm, "_out_valid"}, out_valid, 32'd0);
        chk({nm, "_out_data"}, out_data, 32'd0);
        chk({nm, "_out_idx"}, out_idx, 32'd0);
        chk({nm, "_out_last"}, out_last, 32'd0);
        chk({nm, "_err"}, err, 32'd0);
    endtask

    initial begin
        logic [7:0] bad_p[3];
        nrst      = 1'b0;
        in_valid  = 1'b0;
        sorted    = 16'h0;
        perm      = 8'h0;
        out_ready = 1'b1;
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Basic restore
        log_q.delete();
        offer(16'h7311, 8'h72, 1'b0);
        chk("model_basic_len", exp_q.size(), 32'd4);
        chk("model_basic_b0", exp_q[0].data, 32'd3);
        drain();
        check_log("basic", 4'h3, 4'h1, 4'h7, 4'h1);
        chk("basic_in_ready_after", in_ready, 32'd1);

        // Identity and reverse
        log_q.delete();
        offer(16'hFA50, 8'hE4, 1'b0);
        drain();
        check_log("ident", 4'h0, 4'h5, 4'hA, 4'hF);
        log_q.delete();
        offer(16'hFA50, 8'h1B, 1'b0);
        drain();
        check_log("rev", 4'hF, 4'hA, 4'h5, 4'h0);

        // Invalid permutations
        bad_p[0] = 8'h00; bad_p[1] = 8'h55; bad_p[2] = 8'hE0;
        for (int i = 0; i < 3; i++) begin
            offer(16'h7311, bad_p[i], 1'b0);
            chk("inv_err_pulse", err, 32'd1);
            chk("inv_out_valid", out_valid, 32'd0);
            chk("inv_in_ready", in_ready, 32'd1);
            @(negedge clk);
            chk("inv_err_clear", err, 32'd0);
        end

        // Backpressure after beat 0
        log_q.delete();
        offer(16'h7311, 8'h72, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 32'd1);
            chk("bp_hold_idx", out_idx, 32'd1);
            chk("bp_hold_data", out_data, 32'd1);
        end
        out_ready = 1'b1;
        drain();
        check_log("bp", 4'h3, 4'h1, 4'h7, 4'h1);

        // Back-to-back with in_valid held
        log_q.delete();
        acc_q.delete();
        lastx_q.delete();
        offer(16'h7311, 8'h72, 1'b1);
        offer(16'hFA50, 8'hE4, 1'b0);
        drain();
        chk("b2b_len", log_q.size(), 32'd8);
        if (acc_q.size() == 2 && lastx_q.size() == 2)
            chk("b2b_gap", acc_q[1], lastx_q[0] + 1);
        else
            chk("b2b_counts", acc_q.size() * 16 + lastx_q.size(), 32'h22);
        for (int k = 4; k < 8; k++) begin
            if (k < log_q.size()) chk("b2b_w2_idx", log_q[k].idx, k - 4);
        end

        // Reset mid-word
        log_q.delete();
        offer(16'h7311, 8'h72, 1'b0);
        for (int n = 0; n < 50 && log_q.size() < 2; n++) @(negedge clk);
        chk("midrst_beats_before", log_q.size(), 32'd2);
        #2 nrst = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        nrst = 1'b1;
        log_q.delete();
        @(negedge clk);
        offer(16'hFA50, 8'hE4, 1'b0);
        drain();
        check_log("post_rst", 4'h0, 4'h5, 4'hA, 4'hF);

        // Randomized traffic
        rnd_mode = 1'b1;
        for (int w = 0; w < 300; w++) begin
            logic [7:0] p;
            if ($urandom_range(0, 4) == 0) begin
                p = 8'($urandom);
            end else begin
                int a[4];
                for (int k = 0; k < 4; k++) a[k] = k;
                for (int k = 3; k > 0; k--) begin
                    int r, t;
                    r = $urandom_range(0, k);
                    t = a[k]; a[k] = a[r]; a[r] = t;
                end
                p = {2'(a[3]), 2'(a[2]), 2'(a[1]), 2'(a[0])};
            end
            offer(16'($urandom), p, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b0;
        rnd_mode = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
